// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory address, IF/ID pipeline register.
// Optional self-loop halt detection is enabled by defining FETCH_SELF_LOOP_HALT_EN.
module fetch_stage #(
  parameter int unsigned              WORD_SIZE   = 32,
  parameter int unsigned              BOOT_CYCLES = 2,
  parameter logic [WORD_SIZE-1:0]     RESET_PC    = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 freeze,
  input  logic                 branch_taken,
  input  logic [WORD_SIZE-1:0] branch_addr,
  input  logic [WORD_SIZE-1:0] instruction_in,
  output logic [WORD_SIZE-1:0] pc_to_mem,
  output logic [WORD_SIZE-1:0] if_id_pc,
  output logic [WORD_SIZE-1:0] if_id_instruction,
  output logic                 if_id_valid,
  output logic                 halted
);

  localparam int unsigned      CNT_W     = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
`ifdef FETCH_SELF_LOOP_HALT_EN
  localparam logic [1:0] ST_HALT = 2'd2;
`endif

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] ifpc_q, ifpc_d;
  logic [WORD_SIZE-1:0] instr_q, instr_d;
  logic                 valid_q, valid_d;
  logic [WORD_SIZE-1:0] pc_inc;
  logic [WORD_SIZE-1:0] target_aligned;
`ifdef FETCH_SELF_LOOP_HALT_EN
  logic                 halted_q, halted_d;
  logic                 self_loop;
`endif

  assign pc_inc         = pc_q + WORD_SIZE'(4);
  assign target_aligned = branch_addr & ~WORD_SIZE'(3);
`ifdef FETCH_SELF_LOOP_HALT_EN
  // A branch whose target is the instruction currently in IF/ID spins forever.
  assign self_loop = valid_q && (branch_addr == (ifpc_q - WORD_SIZE'(4)));
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    ifpc_d  = ifpc_q;
    instr_d = instr_q;
    valid_d = valid_q;
`ifdef FETCH_SELF_LOOP_HALT_EN
    halted_d = halted_q;
`endif
    case (state_q)
      ST_BOOT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == BOOT_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (branch_taken) begin
          pc_d    = target_aligned;
          ifpc_d  = '0;
          instr_d = '0;
          valid_d = 1'b0;
`ifdef FETCH_SELF_LOOP_HALT_EN
          if (self_loop) begin
            state_d  = ST_HALT;
            pc_d     = branch_addr;
            halted_d = 1'b1;
          end
`endif
        end else if (!freeze) begin
          pc_d    = pc_inc;
          ifpc_d  = pc_inc;
          instr_d = instruction_in;
          valid_d = 1'b1;
        end
      end
`ifdef FETCH_SELF_LOOP_HALT_EN
      ST_HALT: begin
        state_d = ST_HALT;
      end
`endif
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      ifpc_q  <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      ifpc_q  <= ifpc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

`ifdef FETCH_SELF_LOOP_HALT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  assign pc_to_mem         = pc_q;
  assign if_id_pc          = ifpc_q;
  assign if_id_instruction = instr_q;
  assign if_id_valid       = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then randomized stimulus vs a reference model.
module tb_fetch_stage;

  localparam int unsigned W    = 32;
  localparam int unsigned BOOT = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         freeze;
  logic         branch_taken;
  logic [W-1:0] branch_addr;
  logic [W-1:0] instruction_in;
  logic [W-1:0] pc_to_mem;
  logic [W-1:0] if_id_pc;
  logic [W-1:0] if_id_instruction;
  logic         if_id_valid;
  logic         halted;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [W-1:0] m_pc, m_ifpc, m_instr;
  logic         m_valid, m_halt;
  int           m_cyc;

  fetch_stage #(.WORD_SIZE(W), .BOOT_CYCLES(BOOT), .RESET_PC('0)) dut (
    .clk               (clk),
    .rst               (rst),
    .freeze            (freeze),
    .branch_taken      (branch_taken),
    .branch_addr       (branch_addr),
    .instruction_in    (instruction_in),
    .pc_to_mem         (pc_to_mem),
    .if_id_pc          (if_id_pc),
    .if_id_instruction (if_id_instruction),
    .if_id_valid       (if_id_valid),
    .halted            (halted)
  );

  always #5 clk = ~clk;

  // instruction memory contents, a fixed function of the byte address
  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    if (a == '0) return 32'h8020_000A;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  always_comb instruction_in = mem_word(pc_to_mem);

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, "_pc"},    pc_to_mem,         m_pc);
    check({ph, "_ifpc"},  if_id_pc,          m_ifpc);
    check({ph, "_instr"}, if_id_instruction, m_instr);
    check({ph, "_valid"}, W'(if_id_valid),   W'(m_valid));
    check({ph, "_halt"},  W'(halted),        W'(m_halt));
  endtask

  task automatic model_reset();
    m_pc = '0; m_ifpc = '0; m_instr = '0; m_valid = 1'b0; m_halt = 1'b0; m_cyc = 0;
  endtask

  task automatic model_bubble();
    m_ifpc = '0; m_instr = '0; m_valid = 1'b0;
  endtask

  // One rising edge as described by the fetch rules; edges 1..BOOT after release are boot edges.
  task automatic model_edge(input logic f, input logic b, input logic [W-1:0] a);
    m_cyc++;
    if (m_halt || m_cyc <= BOOT) return;
    if (b) begin
`ifdef FETCH_SELF_LOOP_HALT_EN
      if (m_valid && a == m_ifpc - 32'd4) begin
        m_halt = 1'b1;
        m_pc   = a;
        model_bubble();
        return;
      end
`endif
      m_pc = {a[W-1:2], 2'b00};
      model_bubble();
    end else if (!f) begin
      m_instr = mem_word(m_pc);
      m_pc    = m_pc + 32'd4;
      m_ifpc  = m_pc;
      m_valid = 1'b1;
    end
  endtask

  task automatic step(input logic f, input logic b, input logic [W-1:0] a, input string ph);
    freeze = f; branch_taken = b; branch_addr = a;
    @(posedge clk);
    model_edge(f, b, a);
    #1;
    check_all(ph);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check_all("rst_async");
    repeat (3) @(posedge clk);
    #1;
    check_all("rst_hold");
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    do_reset();

    // boot window ignores freeze and branch
    step(1'b1, 1'b1, 32'h0000_0040, "boot");
    check("t1_boot_valid", W'(if_id_valid), '0);
    step(1'b0, 1'b1, 32'h0000_0080, "boot");
    check("t1_boot_pc", pc_to_mem, 32'd0);
    step(1'b0, 1'b0, '0, "t1");
    check("t1_first_instr", if_id_instruction, 32'h8020_000A);
    check("t1_first_ifpc", if_id_pc, 32'd4);
    check("t1_first_pc", pc_to_mem, 32'd4);

    step(1'b0, 1'b0, '0, "t3a");
    check("t3_pc8", pc_to_mem, 32'd8);
    step(1'b1, 1'b0, '0, "t3_frz");
    step(1'b1, 1'b0, '0, "t3_frz");
    check("t3_frz_pc", pc_to_mem, 32'd8);
    check("t3_frz_ifpc", if_id_pc, 32'd8);
    step(1'b0, 1'b0, '0, "t3_rel");
    check("t3_rel_pc", pc_to_mem, 32'd12);

    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, '0, "t2");
      check("t2_pc", pc_to_mem, W'(16 + 4 * i));
      check("t2_valid", W'(if_id_valid), 32'd1);
    end

    // branch beats freeze, target low bits dropped
    step(1'b1, 1'b1, 32'h0000_006E, "t4");
    check("t4_pc", pc_to_mem, 32'h0000_006C);
    check("t4_bubble_valid", W'(if_id_valid), 32'd0);
    check("t4_bubble_instr", if_id_instruction, 32'd0);
    step(1'b0, 1'b0, '0, "t4b");
    check("t4_capture", if_id_instruction, mem_word(32'h0000_006C));

    step(1'b0, 1'b1, 32'hFFFF_FFFC, "t5");
    check("t5_pc_top", pc_to_mem, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, '0, "t5b");
    check("t5_pc_wrap", pc_to_mem, 32'h0000_0000);
    check("t5_ifpc_wrap", if_id_pc, 32'h0000_0000);

    // self-branch at if_id_pc=232
    step(1'b0, 1'b1, 32'd224, "t6a");
    step(1'b0, 1'b0, '0, "t6b");
    step(1'b0, 1'b0, '0, "t6c");
    check("t6_ifpc", if_id_pc, 32'd232);
    step(1'b0, 1'b1, 32'd228, "t6_br");
    check("t6_pc", pc_to_mem, 32'd228);
    check("t6_valid", W'(if_id_valid), 32'd0);
`ifdef FETCH_SELF_LOOP_HALT_EN
    check("t6_halted", W'(halted), 32'd1);
`else
    check("t6_halted", W'(halted), 32'd0);
`endif
    for (int i = 0; i < 10; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, "t6_hold");
    end
    @(negedge clk);
    do_reset();
    check("t6_rst_halted", W'(halted), 32'd0);
    check("t6_rst_pc", pc_to_mem, 32'd0);

    // randomized run, including occasional mid-run resets
    for (int i = 0; i < 600; i++) begin
      logic         f, b;
      logic [W-1:0] a;
      int unsigned  sel;
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
      end else begin
        f   = ($urandom_range(0, 3) == 0);
        b   = ($urandom_range(0, 7) == 0);
        sel = $urandom_range(0, 2);
        if (sel == 0)      a = m_ifpc - 32'd4;
        else if (sel == 1) a = 32'hFFFF_FFF0 + W'($urandom_range(0, 15));
        else               a = $urandom;
        step(f, b, a, "rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
